// File: rtl/snitch_acc_pkg.sv
// Shared definitions for the accelerator scheduler and the unit it feeds.
package snitch_acc_pkg;

  localparam int unsigned DefIdWidth    = 5;
  localparam int unsigned DefLogCores   = 2;
  localparam int unsigned DefExtIdWidth = DefIdWidth + DefLogCores;

  // Request ID as seen by the shared unit: {core index, core-side ID}.
  typedef logic [DefExtIdWidth-1:0] ext_id_t;

  // Index width that stays at least one bit wide for a single core.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Builds an extended ID from a core index and a core-side ID.
  function automatic ext_id_t ext_id(input logic [DefLogCores-1:0] core,
                                     input logic [DefIdWidth-1:0]  id);
    return {core, id};
  endfunction

endpackage

// File: rtl/snitch_acc_credit.sv
// Per-core saturating in-flight counter; simultaneous inc and dec cancel.
module snitch_acc_credit
  import snitch_acc_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  logic [CntWidth-1:0] cnt;
  logic                do_inc;
  logic                do_dec;

  assign full_o  = (cnt == CntWidth'(MaxOutstanding));
  assign empty_o = (cnt == '0);
  assign do_inc  = inc_i & ~full_o;
  assign do_dec  = dec_i & ~empty_o;

  // Counter update, clamped at both ends.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (do_inc && !do_dec) begin
      cnt <= cnt + CntWidth'(1);
    end else if (do_dec && !do_inc) begin
      cnt <= cnt - CntWidth'(1);
    end
  end

endmodule

// File: rtl/snitch_acc_sched.sv
// Credit-gated round-robin scheduler sharing one accelerator unit among cores.
// Requests pass through a one-entry register stage; responses are routed
// back combinationally using the core index carried in the extended ID.
module snitch_acc_sched
  import snitch_acc_pkg::*;
#(
  parameter int unsigned NrCores        = 4,
  parameter int unsigned IdWidth        = 5,
  parameter int unsigned PayloadWidth   = 160,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned LogCores       = idx_width(NrCores),
  parameter int unsigned ExtIdWidth     = IdWidth + LogCores
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NrCores-1:0]                    core_qvalid_i,
  output logic [NrCores-1:0]                    core_qready_o,
  input  logic [NrCores-1:0][IdWidth-1:0]       core_qid_i,
  input  logic [NrCores-1:0][PayloadWidth-1:0]  core_qdata_i,
  output logic                                  sfu_qvalid_o,
  input  logic                                  sfu_qready_i,
  output logic [ExtIdWidth-1:0]                 sfu_qid_o,
  output logic [PayloadWidth-1:0]               sfu_qdata_o,
  input  logic                                  sfu_pvalid_i,
  output logic                                  sfu_pready_o,
  input  logic [ExtIdWidth-1:0]                 sfu_pid_i,
  input  logic [DataWidth-1:0]                  sfu_pdata_i,
  input  logic                                  sfu_perror_i,
  output logic [NrCores-1:0]                    core_pvalid_o,
  input  logic [NrCores-1:0]                    core_pready_i,
  output logic [IdWidth-1:0]                    core_pid_o,
  output logic [DataWidth-1:0]                  core_pdata_o,
  output logic                                  core_perror_o,
  output logic                                  busy_o,
  output logic                                  unexpected_rsp_o
);

  logic [NrCores-1:0]      full;
  logic [NrCores-1:0]      empty;
  logic [NrCores-1:0]      inc;
  logic [NrCores-1:0]      dec;
  logic [NrCores-1:0]      elig;
  logic [LogCores-1:0]     last_idx;
  logic [LogCores-1:0]     grant_idx;
  logic                    grant_vld;
  logic                    accept;
  logic                    req_hs;
  logic [IdWidth-1:0]      grant_qid;
  logic [PayloadWidth-1:0] grant_qdata;
  logic [LogCores-1:0]     sel;
  logic                    routed;
  logic                    routed_ready;

  logic                    vld_p0;
  logic [ExtIdWidth-1:0]   id_p0;
  logic [PayloadWidth-1:0] data_p0;

  assign elig   = core_qvalid_i & ~full;
  assign accept = ~vld_p0 | sfu_qready_i;
  assign req_hs = grant_vld & accept & ~rst_i;

  // Round-robin search over eligible cores, starting after the last grant.
  always_comb begin
    int unsigned idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NrCores; k++) begin
      idx = (32'(last_idx) + 32'd1 + k) % NrCores;
      for (int unsigned i = 0; i < NrCores; i++) begin
        if (!grant_vld && (i == idx) && elig[i]) begin
          grant_vld = 1'b1;
          grant_idx = LogCores'(i);
        end
      end
    end
  end

  // Grant decode, credit increments and granted-request mux.
  always_comb begin
    grant_qid   = '0;
    grant_qdata = '0;
    for (int unsigned i = 0; i < NrCores; i++) begin
      core_qready_o[i] = req_hs & (grant_idx == LogCores'(i));
      inc[i]           = req_hs & (grant_idx == LogCores'(i));
      if (grant_idx == LogCores'(i)) begin
        grant_qid   = core_qid_i[i];
        grant_qdata = core_qdata_i[i];
      end
    end
  end

  // Stage p0 control: occupancy and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p0   <= 1'b0;
      last_idx <= LogCores'(NrCores - 1);
    end else begin
      if (accept) vld_p0 <= req_hs;
      if (req_hs) last_idx <= grant_idx;
    end
  end

  // Stage p0 data: loaded only on a core handshake, held under backpressure.
  always_ff @(posedge clk_i) begin
    if (req_hs) begin
      id_p0   <= {grant_idx, grant_qid};
      data_p0 <= grant_qdata;
    end
  end

  // Data registers are not reset, so the outputs read zero while empty.
  assign sfu_qvalid_o = vld_p0;
  assign sfu_qid_o    = vld_p0 ? id_p0 : '0;
  assign sfu_qdata_o  = vld_p0 ? data_p0 : '0;

  assign sel = sfu_pid_i[ExtIdWidth-1:IdWidth];

  // Response routing; responses for unknown or idle cores are swallowed.
  always_comb begin
    routed       = 1'b0;
    routed_ready = 1'b0;
    for (int unsigned i = 0; i < NrCores; i++) begin
      if ((sel == LogCores'(i)) && !empty[i]) begin
        routed       = 1'b1;
        routed_ready = core_pready_i[i];
      end
    end
    for (int unsigned i = 0; i < NrCores; i++) begin
      core_pvalid_o[i] = sfu_pvalid_i & routed & (sel == LogCores'(i));
    end
  end

  assign dec              = core_pvalid_o & core_pready_i;
  assign sfu_pready_o     = routed ? routed_ready : 1'b1;
  assign unexpected_rsp_o = sfu_pvalid_i & ~routed;
  assign core_pid_o       = sfu_pid_i[IdWidth-1:0];
  assign core_pdata_o     = sfu_pdata_i;
  assign core_perror_o    = sfu_perror_i;
  assign busy_o           = vld_p0 | ~(&empty);

  for (genvar g = 0; g < NrCores; g++) begin : gen_credit
    snitch_acc_credit #(
      .MaxOutstanding(MaxOutstanding)
    ) i_credit (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .inc_i  (inc[g]),
      .dec_i  (dec[g]),
      .full_o (full[g]),
      .empty_o(empty[g])
    );
  end

endmodule

// File: tb/tb_snitch_acc_sched.sv
// Self-checking bench for snitch_acc_sched (4-core and 3-core instances).
module tb_snitch_acc_sched;

  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-core instance signals
  logic [3:0]          qvalid, qready, core_pvalid, core_pready;
  logic [3:0][4:0]     qid;
  logic [3:0][159:0]   qdata;
  logic                sfu_qvalid, sfu_qready, pvalid, pready, perror, core_perror, busy, unexp;
  logic [6:0]          sfu_qid, pid;
  logic [159:0]        sfu_qdata;
  logic [31:0]         pdata, core_pdata;
  logic [4:0]          core_pid;

  // 3-core instance signals
  logic [2:0]          b_qvalid, b_qready, b_core_pvalid, b_core_pready;
  logic [2:0][4:0]     b_qid;
  logic [2:0][159:0]   b_qdata;
  logic                b_sfu_qvalid, b_sfu_qready, b_pvalid, b_pready, b_perror, b_core_perror, b_busy, b_unexp;
  logic [6:0]          b_sfu_qid, b_pid;
  logic [159:0]        b_sfu_qdata;
  logic [31:0]         b_pdata, b_core_pdata;
  logic [4:0]          b_core_pid;

  int checks = 0;
  int passed = 0;

  snitch_acc_sched #(.NrCores(4)) u0 (
    .clk_i(clk), .rst_i(rst),
    .core_qvalid_i(qvalid), .core_qready_o(qready), .core_qid_i(qid), .core_qdata_i(qdata),
    .sfu_qvalid_o(sfu_qvalid), .sfu_qready_i(sfu_qready), .sfu_qid_o(sfu_qid), .sfu_qdata_o(sfu_qdata),
    .sfu_pvalid_i(pvalid), .sfu_pready_o(pready), .sfu_pid_i(pid), .sfu_pdata_i(pdata), .sfu_perror_i(perror),
    .core_pvalid_o(core_pvalid), .core_pready_i(core_pready), .core_pid_o(core_pid),
    .core_pdata_o(core_pdata), .core_perror_o(core_perror), .busy_o(busy), .unexpected_rsp_o(unexp)
  );

  snitch_acc_sched #(.NrCores(3)) u1 (
    .clk_i(clk), .rst_i(rst),
    .core_qvalid_i(b_qvalid), .core_qready_o(b_qready), .core_qid_i(b_qid), .core_qdata_i(b_qdata),
    .sfu_qvalid_o(b_sfu_qvalid), .sfu_qready_i(b_sfu_qready), .sfu_qid_o(b_sfu_qid), .sfu_qdata_o(b_sfu_qdata),
    .sfu_pvalid_i(b_pvalid), .sfu_pready_o(b_pready), .sfu_pid_i(b_pid), .sfu_pdata_i(b_pdata), .sfu_perror_i(b_perror),
    .core_pvalid_o(b_core_pvalid), .core_pready_i(b_core_pready), .core_pid_o(b_core_pid),
    .core_pdata_o(b_core_pdata), .core_perror_o(b_core_perror), .busy_o(b_busy), .unexpected_rsp_o(b_unexp)
  );

  function automatic logic [159:0] rnd160();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Advance to just after the next rising edge (input drive point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Move to the sampling point, well before the next rising edge.
  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    qvalid = '0; sfu_qready = 1'b0; pvalid = 1'b0; pid = '0; pdata = '0; perror = 1'b0; core_pready = '0;
    b_qvalid = '0; b_sfu_qready = 1'b0; b_pvalid = 1'b0; b_pid = '0; b_pdata = '0; b_perror = 1'b0; b_core_pready = '0;
    for (int i = 0; i < 4; i++) begin qid[i] = '0; qdata[i] = '0; end
    for (int i = 0; i < 3; i++) begin b_qid[i] = '0; b_qdata[i] = '0; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    qvalid = 4'hF; sfu_qready = 1'b1;
    for (int i = 0; i < 4; i++) begin qid[i] = 5'($urandom); qdata[i] = rnd160(); end
    step(); step(); settle();
    checks++; if (qready !== 4'b0) $display("FAIL reset_qready got=%b exp=0000", qready); else passed++;
    checks++; if (sfu_qvalid !== 1'b0) $display("FAIL reset_qvalid got=%b exp=0", sfu_qvalid); else passed++;
    checks++; if (sfu_qid !== 7'h0) $display("FAIL reset_qid got=%h exp=00", sfu_qid); else passed++;
    checks++; if (sfu_qdata !== 160'h0) $display("FAIL reset_qdata got=%h exp=0", sfu_qdata); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    checks++; if (unexp !== 1'b0) $display("FAIL reset_unexp got=%b exp=0", unexp); else passed++;
    checks++; if (b_qready !== 3'b0) $display("FAIL reset_b_qready got=%b exp=000", b_qready); else passed++;
  endtask

  task automatic test_round_robin();
    logic [6:0] exp_id;
    logic [3:0] exp_rdy;
    do_reset();
    qvalid = 4'hF; sfu_qready = 1'b1;
    for (int i = 0; i < 4; i++) begin qid[i] = 5'(i + 1); qdata[i] = rnd160(); end
    settle();
    checks++; if (qready !== 4'b0001) $display("FAIL rr_first got=%b exp=0001", qready); else passed++;
    for (int k = 0; k < 4; k++) begin
      step(); settle();
      exp_id = 7'(k * 32 + k + 1);
      exp_rdy = '0; exp_rdy[(k + 1) % 4] = 1'b1;
      checks++; if (sfu_qvalid !== 1'b1 || sfu_qid !== exp_id)
        $display("FAIL rr_qid%0d got=%b/%h exp=1/%h", k, sfu_qvalid, sfu_qid, exp_id); else passed++;
      checks++; if (sfu_qdata !== qdata[k]) $display("FAIL rr_qdata%0d got=%h exp=%h", k, sfu_qdata, qdata[k]); else passed++;
      checks++; if (qready !== exp_rdy) $display("FAIL rr_grant%0d got=%b exp=%b", k, qready, exp_rdy); else passed++;
    end
  endtask

  task automatic test_credit_limit();
    do_reset();
    qvalid = 4'b0100; sfu_qready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      qid[2] = 5'(n);
      settle();
      checks++; if (qready !== 4'b0100) $display("FAIL credit_accept%0d got=%b exp=0100", n, qready); else passed++;
      step();
    end
    settle();
    checks++; if (qready !== 4'b0000) $display("FAIL credit_block got=%b exp=0000", qready); else passed++;
    step(); settle();
    checks++; if (qready !== 4'b0000) $display("FAIL credit_block_hold got=%b exp=0000", qready); else passed++;
    step();
    pvalid = 1'b1; pid = 7'h47; core_pready = 4'b0100;
    settle();
    checks++; if (core_pvalid !== 4'b0100 || pready !== 1'b1 || core_pid !== 5'd7)
      $display("FAIL credit_rsp got=%b/%b/%h exp=0100/1/07", core_pvalid, pready, core_pid); else passed++;
    checks++; if (qready !== 4'b0000) $display("FAIL credit_same_cycle got=%b exp=0000", qready); else passed++;
    step();
    pvalid = 1'b0; core_pready = '0;
    settle();
    checks++; if (qready !== 4'b0100) $display("FAIL credit_release got=%b exp=0100", qready); else passed++;
  endtask

  task automatic test_backpressure();
    logic [159:0] held;
    do_reset();
    qvalid = 4'b0011; qid[0] = 5'd9; qid[1] = 5'd10; qdata[0] = rnd160(); qdata[1] = rnd160();
    sfu_qready = 1'b1;
    held = qdata[0];
    settle();
    step();
    qvalid = 4'b0010; sfu_qready = 1'b0; qdata[0] = rnd160();
    for (int n = 0; n < 3; n++) begin
      settle();
      checks++; if (sfu_qvalid !== 1'b1 || sfu_qid !== 7'h09 || sfu_qdata !== held)
        $display("FAIL bp_hold%0d got=%b/%h exp=1/09", n, sfu_qvalid, sfu_qid); else passed++;
      checks++; if (qready !== 4'b0000) $display("FAIL bp_noready%0d got=%b exp=0000", n, qready); else passed++;
      step();
    end
    sfu_qready = 1'b1;
    settle();
    checks++; if (qready !== 4'b0010) $display("FAIL bp_release got=%b exp=0010", qready); else passed++;
    step(); settle();
    checks++; if (sfu_qid !== 7'h2A) $display("FAIL bp_next got=%h exp=2a", sfu_qid); else passed++;
  endtask

  task automatic test_response_stall();
    do_reset();
    qvalid = 4'b0010; qid[1] = 5'd5; sfu_qready = 1'b1;
    settle();
    checks++; if (qready !== 4'b0010) $display("FAIL stall_issue got=%b exp=0010", qready); else passed++;
    step();
    qvalid = '0;
    pvalid = 1'b1; pid = 7'h25; pdata = $urandom; perror = 1'b1; core_pready = 4'b1101;
    for (int n = 0; n < 2; n++) begin
      settle();
      checks++; if (core_pvalid !== 4'b0010 || core_pid !== 5'd5 || pready !== 1'b0)
        $display("FAIL stall_wait%0d got=%b/%h/%b exp=0010/05/0", n, core_pvalid, core_pid, pready); else passed++;
      checks++; if (core_pdata !== pdata || core_perror !== 1'b1)
        $display("FAIL stall_pass%0d got=%h/%b exp=%h/1", n, core_pdata, core_perror, pdata); else passed++;
      step();
    end
    core_pready = 4'b0010;
    settle();
    checks++; if (pready !== 1'b1) $display("FAIL stall_ready got=%b exp=1", pready); else passed++;
    step();
    pvalid = 1'b0;
    settle();
    checks++; if (busy !== 1'b0) $display("FAIL stall_busy got=%b exp=0", busy); else passed++;
    step();
    pvalid = 1'b1; pid = 7'h25;
    settle();
    checks++; if (unexp !== 1'b1 || core_pvalid !== 4'b0 || pready !== 1'b1)
      $display("FAIL stall_redrop got=%b/%b/%b exp=1/0000/1", unexp, core_pvalid, pready); else passed++;
    step();
    pvalid = 1'b0;
  endtask

  task automatic test_unexpected();
    do_reset();
    b_qvalid = 3'b001; b_qid[0] = 5'd3; b_sfu_qready = 1'b1;
    settle();
    checks++; if (b_qready !== 3'b001) $display("FAIL unexp_issue got=%b exp=001", b_qready); else passed++;
    step();
    b_qvalid = '0;
    b_pvalid = 1'b1; b_pid = 7'h61; b_core_pready = 3'b111;
    settle();
    checks++; if (b_pready !== 1'b1 || b_unexp !== 1'b1 || b_core_pvalid !== 3'b000)
      $display("FAIL unexp_drop got=%b/%b/%b exp=1/1/000", b_pready, b_unexp, b_core_pvalid); else passed++;
    step();
    b_pid = 7'h03;
    settle();
    checks++; if (b_unexp !== 1'b0 || b_core_pvalid !== 3'b001)
      $display("FAIL unexp_cnt_kept got=%b/%b exp=0/001", b_unexp, b_core_pvalid); else passed++;
    step();
    b_pvalid = 1'b0;
    settle();
    checks++; if (b_busy !== 1'b0) $display("FAIL unexp_busy got=%b exp=0", b_busy); else passed++;
  endtask

  task automatic test_reset_midop();
    do_reset();
    qvalid = 4'b0011; qid[0] = 5'd1; qid[1] = 5'd2; sfu_qready = 1'b1;
    settle(); step(); settle(); step();
    qvalid = '0;
    settle();
    checks++; if (busy !== 1'b1) $display("FAIL midrst_busy_before got=%b exp=1", busy); else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    checks++; if (busy !== 1'b0 || sfu_qvalid !== 1'b0)
      $display("FAIL midrst_cleared got=%b/%b exp=0/0", busy, sfu_qvalid); else passed++;
    step();
    pvalid = 1'b1; pid = 7'h01; core_pready = 4'hF;
    settle();
    checks++; if (unexp !== 1'b1 || core_pvalid !== 4'b0 || pready !== 1'b1)
      $display("FAIL midrst_drop0 got=%b/%b/%b exp=1/0000/1", unexp, core_pvalid, pready); else passed++;
    step();
    pid = 7'h22;
    settle();
    checks++; if (unexp !== 1'b1 || core_pvalid !== 4'b0 || pready !== 1'b1)
      $display("FAIL midrst_drop1 got=%b/%b/%b exp=1/0000/1", unexp, core_pvalid, pready); else passed++;
    step();
    pvalid = 1'b0; core_pready = '0;
    settle();
    checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else passed++;
  endtask

  // Random traffic against a transaction-level model: per-core in-flight
  // counts, a one-slot stage and a pool of requests held by the unit.
  task automatic test_random();
    int           cnt_m [4];
    int           last_m;
    bit           stg_v;
    logic [6:0]   stg_id;
    logic [159:0] stg_data;
    logic [6:0]   inflight [$];
    int           rsp_idx, g;
    bit           accept, found, routed, any_cnt;
    logic [1:0]   sel;
    logic [3:0]   exp_qready, exp_pvalid;
    bit           exp_pready, exp_unexp;
    do_reset();
    for (int i = 0; i < 4; i++) cnt_m[i] = 0;
    last_m = 3; stg_v = 1'b0; stg_id = '0; stg_data = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      qvalid = 4'($urandom);
      for (int i = 0; i < 4; i++) begin qid[i] = 5'($urandom); qdata[i] = rnd160(); end
      sfu_qready = ($urandom_range(0, 3) != 0);
      core_pready = 4'($urandom);
      pdata = $urandom; perror = 1'($urandom);
      rsp_idx = -1;
      if (inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
        rsp_idx = $urandom_range(0, inflight.size() - 1);
        pvalid = 1'b1; pid = inflight[rsp_idx];
      end else begin
        pvalid = 1'b0; pid = 7'($urandom);
      end
      settle();

      accept = !stg_v || sfu_qready;
      found = 1'b0; g = 0;
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (last_m + 1 + k) % 4;
        if (!found && qvalid[c] && cnt_m[c] < MO) begin found = 1'b1; g = c; end
      end
      exp_qready = '0;
      if (accept && found) exp_qready[g] = 1'b1;
      sel = pid[6:5];
      routed = (cnt_m[sel] != 0);
      exp_pvalid = '0;
      if (pvalid && routed) exp_pvalid[sel] = 1'b1;
      exp_pready = routed ? core_pready[sel] : 1'b1;
      exp_unexp = pvalid && !routed;
      any_cnt = 1'b0;
      for (int i = 0; i < 4; i++) if (cnt_m[i] != 0) any_cnt = 1'b1;

      checks++; if (qready !== exp_qready) $display("FAIL rnd_qready c%0d got=%b exp=%b", cyc, qready, exp_qready); else passed++;
      checks++; if (sfu_qvalid !== stg_v) $display("FAIL rnd_qvalid c%0d got=%b exp=%b", cyc, sfu_qvalid, stg_v); else passed++;
      if (stg_v) begin
        checks++; if (sfu_qid !== stg_id || sfu_qdata !== stg_data)
          $display("FAIL rnd_stage c%0d got=%h exp=%h", cyc, sfu_qid, stg_id); else passed++;
      end
      checks++; if (core_pvalid !== exp_pvalid) $display("FAIL rnd_pvalid c%0d got=%b exp=%b", cyc, core_pvalid, exp_pvalid); else passed++;
      checks++; if (pready !== exp_pready) $display("FAIL rnd_pready c%0d got=%b exp=%b", cyc, pready, exp_pready); else passed++;
      checks++; if (unexp !== exp_unexp) $display("FAIL rnd_unexp c%0d got=%b exp=%b", cyc, unexp, exp_unexp); else passed++;
      checks++; if (busy !== (stg_v || any_cnt)) $display("FAIL rnd_busy c%0d got=%b exp=%b", cyc, busy, stg_v || any_cnt); else passed++;

      if (pvalid && routed && core_pready[sel]) begin
        cnt_m[sel]--;
        inflight.delete(rsp_idx);
      end
      if (stg_v && sfu_qready) inflight.push_back(stg_id);
      if (accept) begin
        stg_v = found;
        if (found) begin
          stg_id = 7'(g * 32 + int'(qid[g]));
          stg_data = qdata[g];
          cnt_m[g]++;
          last_m = g;
        end
      end
      step();
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_round_robin();
    test_credit_limit();
    test_backpressure();
    test_response_stall();
    test_unexpected();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
